// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: synchronises completed bytes into sysclk,
// queues them, and exposes data/status registers plus a data-pending interrupt.
module uart_rx_fifo #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [31:0] DATA_ADDR  = 32'h40000024,
  parameter logic [31:0] STAT_ADDR  = 32'h40000028
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [2:0]            sync_q;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow, ie;
  logic [7:0]            mem [DEPTH];

  logic push_req, stat_wr, pop_req, clr_req, flush_req;
  logic empty, full, do_pop, do_push, drop;
  logic [31:0] stat;

  // Rising-edge detect on the synchronised completion strobe: one push per byte.
  assign push_req  = sync_q[1] & ~sync_q[2];
  assign stat_wr   = wr && (addr == STAT_ADDR);
  assign pop_req   = stat_wr & wdata[0];
  assign clr_req   = stat_wr & wdata[1];
  assign flush_req = stat_wr & wdata[2];

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop_req & ~empty;
  // A same-cycle pop frees the slot a full FIFO needs for the incoming byte.
  assign do_push = push_req & (~full | do_pop);
  assign drop    = push_req & full & ~do_pop & ~flush_req;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      ie       <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], rx_valid};
      if (stat_wr) ie <= wdata[3];
      if (drop)         overflow <= 1'b1;
      else if (clr_req) overflow <= 1'b0;
      if (flush_req) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge sysclk) begin
    if (do_push && !flush_req) mem[wr_ptr] <= rx_data;
  end

  always_comb begin
    stat                     = '0;
    stat[0]                  = empty;
    stat[1]                  = full;
    stat[2]                  = overflow;
    stat[3]                  = ie;
    stat[8 +: DEPTH_LOG2+1]  = count;
    rdata                    = '0;
    if (rd) begin
      if (addr == DATA_ADDR) rdata = empty ? 32'd0 : {24'd0, mem[rd_ptr]};
      else if (addr == STAT_ADDR) rdata = stat;
    end
  end

  assign irq = ~empty & ie;
endmodule
